seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, digit count (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (legal >= 1).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, when 1 inverts seg and an at the pins.
REQ-004 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous active-high reset; all logic on rising clk.
REQ-005 SHALL have ports: digits  in  4*NUM_DIGITS  packed digit codes, digit 0 in bits [3:0], digit 0 rightmost; dp_in  in  NUM_DIGITS  decimal point per digit.
REQ-006 SHALL have ports: load  in  1  capture digits/dp_in into shadow; lzb  in  1  leading-zero blanking enable.
REQ-007 SHALL have ports: seg  out  7  segments {g,f,e,d,c,b,a}; dp  out  1  decimal point; an  out  NUM_DIGITS  one-hot digit select; frame_done  out  1  one-cycle pulse per full scan.

Function
REQ-008 SHALL capture digits and dp_in into the shadow register on any cycle with load=1; display SHALL use only the shadow.
REQ-009 SHALL count refresh counter 0..REFRESH_DIV-1; tick asserted when count = REFRESH_DIV-1, counter wraps to 0.
REQ-010 SHALL advance digit index on tick, NUM_DIGITS-1 wrapping to 0; frame_done=1 for the cycle after a wrap-causing tick.
REQ-011 SHALL register seg, dp, an every cycle from current index and shadow: one-cycle latency after any index or shadow change.
REQ-012 SHALL encode active-high (a..g): 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg.
REQ-013 SHALL, when lzb=1, blank segments of digit i>0 if shadow digits i..NUM_DIGITS-1 are all 0; digit 0 never blanked; an and dp unaffected by blanking.
REQ-014 SHALL apply load and tick in the same cycle together; the following output reflects new shadow and new index.
REQ-015 SHALL, with NUM_DIGITS=1, hold index 0 and pulse frame_done once per tick; with REFRESH_DIV=1, tick every cycle.
REQ-016 SHALL drive exactly one an bit active (logical) outside reset.

Reset
REQ-017 SHALL on reset=1 clear shadow to 0, counter to 0, index to 0, frame_done to 0.
REQ-018 SHALL on reset=1 drive seg, dp off and all an inactive (pin level per ACTIVE_LOW); first cycle after release shows digit 0.
REQ-019 SHALL let reset mid-scan override load and tick in the same cycle.

Configuration
REQ-020 SHALL, with HEX_DIGITS_EN defined, encode 10..15 as A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.
REQ-021 SHALL, without HEX_DIGITS_EN, blank segments for codes 10..15 (dp still follows dp shadow); such codes count as nonzero for REQ-013.

Structure
REQ-022 SHALL place in package seg_scan_pkg: seg_t (7-bit typedef), DIGIT_W=4, and the sixteen segment pattern constants.
REQ-023 SHALL instantiate one combinational sub-module seg7_encode (4-bit code, blank -> seg_t) inside seg_scan_driver.

Verification
REQ-024 SHALL cover reset: reset=1 two cycles, ACTIVE_LOW=1 -> seg=7'h7F, an=4'hF, frame_done=0; release -> an=4'hE next cycle.
REQ-025 SHALL cover scan: REFRESH_DIV=3, load digits=16'h1234 -> an cycles E,D,B,7 every 3 cycles, seg patterns 4,3,2,1, frame_done once per 12 cycles.
REQ-026 SHALL cover blanking: lzb=1, digits=16'h0050 -> digits 3,2 blanked, digit 1 shows 5, digit 0 shows 0; digits=16'h0000 -> only digit 0 lit showing 0.
REQ-027 SHALL cover simultaneous load+tick: load 16'h9999 on tick cycle -> next cycle seg shows 9 on new index.
REQ-028 SHALL cover hex: digits=16'h00AF with and without HEX_DIGITS_EN -> digit 0 aefg / blank, digit 1 abcefg / blank.
REQ-029 SHALL cover mid-scan reset at index 2 -> next cycle all off, shadow 0, scan restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and segment patterns for the multiplexed seven-segment scanner.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg_scan_pkg;

   typedef logic [6:0] seg_t;

   localparam int DIGIT_W = 4;

   localparam seg_t SEG_0 = 7'h3F;
   localparam seg_t SEG_1 = 7'h06;
   localparam seg_t SEG_2 = 7'h5B;
   localparam seg_t SEG_3 = 7'h4F;
   localparam seg_t SEG_4 = 7'h66;
   localparam seg_t SEG_5 = 7'h6D;
   localparam seg_t SEG_6 = 7'h7D;
   localparam seg_t SEG_7 = 7'h07;
   localparam seg_t SEG_8 = 7'h7F;
   localparam seg_t SEG_9 = 7'h6F;
   localparam seg_t SEG_A = 7'h77;
   localparam seg_t SEG_B = 7'h7C;
   localparam seg_t SEG_C = 7'h39;
   localparam seg_t SEG_D = 7'h5E;
   localparam seg_t SEG_E = 7'h79;
   localparam seg_t SEG_F = 7'h71;

   function automatic seg_t seg_lookup(input logic [DIGIT_W-1:0] code);
      case (code)
         4'h0: return SEG_0;
         4'h1: return SEG_1;
         4'h2: return SEG_2;
         4'h3: return SEG_3;
         4'h4: return SEG_4;
         4'h5: return SEG_5;
         4'h6: return SEG_6;
         4'h7: return SEG_7;
         4'h8: return SEG_8;
         4'h9: return SEG_9;
         4'hA: return SEG_A;
         4'hB: return SEG_B;
         4'hC: return SEG_C;
         4'hD: return SEG_D;
         4'hE: return SEG_E;
         default: return SEG_F;
      endcase
   endfunction

endpackage

// File: rtl/seg_scan_driver_encode.sv
// Combinational digit-code to active-high segment encoder.
// HEX_DIGITS_EN: when defined, codes 10..15 show A-F; otherwise they are blank.
module seg7_encode
   import seg_scan_pkg::*;
(
   input  logic [DIGIT_W-1:0] code,
   input  logic               blank,
   output seg_t               seg
);

   always_comb begin
      seg = '0;
      if (!blank) begin
`ifdef HEX_DIGITS_EN
         seg = seg_lookup(code);
`else
         if (code <= 4'd9) seg = seg_lookup(code);
`endif
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with shadow capture and leading-zero blanking.
// Outputs are registered from the current index/shadow; HEX_DIGITS_EN selects A-F glyphs.
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]         dp_in,
   input  logic                          load,
   input  logic                          lzb,
   output seg_t                          seg,
   output logic                          dp,
   output logic [NUM_DIGITS-1:0]         an,
   output logic                          frame_done
);

   localparam int   IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int   CW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic INV = (ACTIVE_LOW != 0);

   logic [DIGIT_W*NUM_DIGITS-1:0] sh_digits;
   logic [NUM_DIGITS-1:0]         sh_dp;
   logic [CW-1:0]                 cnt;
   logic [IW-1:0]                 idx;
   logic                          tick;
   logic                          wrap;
   logic [DIGIT_W-1:0]            cur_code;
   logic                          cur_dp;
   logic                          blank;
   logic [NUM_DIGITS-1:0]         an_vec;
   seg_t                          enc_seg;

   assign tick = (cnt == CW'(REFRESH_DIV - 1));
   assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

   // A digit is blanked only when it and every more-significant digit are zero.
   always_comb begin
      cur_code = '0;
      cur_dp   = 1'b0;
      an_vec   = '0;
      blank    = lzb && (idx != '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_code  = sh_digits[i*DIGIT_W +: DIGIT_W];
            cur_dp    = sh_dp[i];
            an_vec[i] = 1'b1;
         end
         if (i >= int'(idx) && sh_digits[i*DIGIT_W +: DIGIT_W] != '0) blank = 1'b0;
      end
   end

   seg7_encode u_encode (
      .code  (cur_code),
      .blank (blank),
      .seg   (enc_seg)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_digits  <= '0;
         sh_dp      <= '0;
         cnt        <= '0;
         idx        <= '0;
         frame_done <= 1'b0;
      end else begin
         if (load) begin
            sh_digits <= digits;
            sh_dp     <= dp_in;
         end
         cnt        <= tick ? '0 : cnt + 1'b1;
         if (tick) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         frame_done <= wrap;
      end
   end

   // Pin polarity applied at the register so the pins never glitch.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg <= {7{INV}};
         dp  <= INV;
         an  <= {NUM_DIGITS{INV}};
      end else begin
         seg <= enc_seg ^ {7{INV}};
         dp  <= cur_dp ^ INV;
         an  <= an_vec ^ {NUM_DIGITS{INV}};
      end
   end

endmodule
